// File: rtl/vector_xfer_arbiter_if.sv
// Link-speed type shared with the arbiter, plus the bundle of source-request and
// FIFO-write signals around the arbiter.
package vector_xfer_pkg;
  typedef enum logic [1:0] {
    LINK_10   = 2'd0,
    LINK_100  = 2'd1,
    LINK_1000 = 2'd2
  } link_select_t;
endpackage

interface vector_xfer_if #(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = 10,
  parameter int unsigned IDW = $clog2(N)
) ();
  logic [N-1:0]         req_valid;
  logic [N-1:0][W-1:0]  req_vector;
  logic [N-1:0]         req_ready;
  logic                 ovalid;
  logic [IDW+W-1:0]     ovector;

  // master: the arbiter; slave: the sources and the FIFO write side
  modport master (
    input  req_valid,
    input  req_vector,
    output req_ready,
    output ovalid,
    output ovector
  );

  modport slave (
    output req_valid,
    output req_vector,
    input  req_ready,
    input  ovalid,
    input  ovector
  );
endinterface

// File: rtl/vector_xfer_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among pN sources, with credit-based
// flow control and link-speed-dependent write pacing.
module vector_xfer_arbiter
  import vector_xfer_pkg::*;
#(
  parameter int unsigned pN       = 4,
  parameter int unsigned pWIDTH   = 10,
  parameter int unsigned pIDW     = $clog2(pN),
  parameter int unsigned pCREDITS = 8,
  parameter int unsigned pGAP_100 = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  link_select_t                  link_speed,
  vector_xfer_if.master                 bus,
  input  logic                          credit_return,
  output logic [$clog2(pCREDITS+1)-1:0] credits_avail,
  output logic                          credit_err
);

  localparam int unsigned CW = $clog2(pCREDITS + 1);
  localparam int unsigned GW = (pGAP_100 > 2) ? $clog2(pGAP_100) : 1;

  typedef enum logic [0:0] {StIdle, StGap} state_e;

  state_e                  state_q;
  logic [GW-1:0]           gap_cnt_q;
  logic [pIDW-1:0]         rr_last_q;
  logic [CW-1:0]           credits_q;
  logic                    credit_err_q;
  logic                    ovalid_q;
  logic [pIDW+pWIDTH-1:0]  ovector_q;

  logic [pIDW-1:0]         grant;
  logic [pIDW-1:0]         cand;
  logic                    found;
  logic                    accept;

  // First valid source searching upward from the one after the last winner.
  always_comb begin
    grant = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= pN; i++) begin
      cand = pIDW'((32'(rr_last_q) + i) % pN);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  assign accept = (state_q == StIdle) && found && (credits_q != '0) && !reset;

  always_comb begin
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready = pN'(1) << grant;
    end
  end

  assign bus.ovalid    = ovalid_q;
  assign bus.ovector   = ovector_q;
  assign credits_avail = credits_q;
  assign credit_err    = credit_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      gap_cnt_q    <= '0;
      rr_last_q    <= pIDW'(pN - 1);
      credits_q    <= CW'(pCREDITS);
      credit_err_q <= 1'b0;
      ovalid_q     <= 1'b0;
      ovector_q    <= '0;
    end else begin
      ovalid_q <= accept;
      if (accept) begin
        ovector_q <= {grant, bus.req_vector[grant]};
        rr_last_q <= grant;
      end

      unique case (state_q)
        StIdle: begin
          if (accept && (link_speed != LINK_1000)) begin
            state_q   <= StGap;
            gap_cnt_q <= GW'(pGAP_100 - 2);
          end
        end
        StGap: begin
          if ((link_speed == LINK_1000) || (gap_cnt_q == '0)) begin
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      // A return at full count is a protocol error; the count saturates.
      if (accept && !credit_return) begin
        credits_q <= credits_q - 1'b1;
      end else if (!accept && credit_return) begin
        if (credits_q == CW'(pCREDITS)) begin
          credit_err_q <= 1'b1;
        end else begin
          credits_q <= credits_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_xfer_arbiter.sv
// Directed bench for vector_xfer_arbiter: expected FIFO writes are queued as each
// accept is expected and popped when ovalid appears.
module tb_vector_xfer_arbiter;
  import vector_xfer_pkg::*;

  logic         clk;
  logic         reset;
  link_select_t link_speed;
  logic         credit_return;
  logic [3:0]   credits_avail;
  logic         credit_err;

  int tests = 0;
  int fails = 0;

  logic [11:0] exp_q[$];
  logic [3:0][9:0] vecs;

  vector_xfer_if #(.N(4), .W(10)) bus ();

  vector_xfer_arbiter #(
    .pN(4), .pWIDTH(10), .pCREDITS(8), .pGAP_100(10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .link_speed   (link_speed),
    .bus          (bus.master),
    .credit_return(credit_return),
    .credits_avail(credits_avail),
    .credit_err   (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] expw(input int id);
    logic [1:0] id2;
    id2 = 2'(id);
    return {id2, vecs[id2]};
  endfunction

  function automatic logic [3:0] oh(input int id);
    return 4'b0001 << (id % 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    credit_return = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard pop on every write strobe.
  always @(negedge clk) begin
    if (bus.ovalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ovalid", 32'(bus.ovalid), 32'd0);
      end else begin
        chk("ovector", 32'(bus.ovector), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs = {10'h3C3, 10'h155, 10'h2AA, 10'h0F0};
    bus.req_vector = vecs;
    bus.req_valid  = '0;
    credit_return  = 1'b0;
    link_speed     = LINK_1000;
    reset          = 1'b1;
    tick();
    tick();
    sample();
    chk("rst_ovalid", 32'(bus.ovalid), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_credits", 32'(credits_avail), 32'd8);
    chk("rst_err", 32'(credit_err), 32'd0);
    chk("rst_ovector", 32'(bus.ovector), 32'd0);

    // T1: single request from source 2
    tick();
    reset = 1'b0;
    bus.req_valid = 4'b0100;
    sample();
    chk("t1_ready", 32'(bus.req_ready), 32'h4);
    exp_q.push_back(expw(2));
    tick();
    bus.req_valid = '0;
    sample();
    chk("t1_ready_off", 32'(bus.req_ready), 32'd0);
    chk("t1_ovalid", 32'(bus.ovalid), 32'd1);
    chk("t1_credits", 32'(credits_avail), 32'd7);
    tick();
    sample();
    chk("t1_ovalid_pulse", 32'(bus.ovalid), 32'd0);

    // T2: round robin, back-to-back, credits returned every cycle
    do_reset();
    bus.req_valid = 4'hF;
    credit_return = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample();
      chk("t2_ready", 32'(bus.req_ready), 32'(oh(i)));
      chk("t2_credits", 32'(credits_avail), 32'd8);
      exp_q.push_back(expw(i % 4));
      tick();
    end
    bus.req_valid = '0;
    credit_return = 1'b0;
    sample();

    // T3: credit exhaustion, then a single returned credit
    do_reset();
    bus.req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      sample();
      chk("t3_ready", 32'(bus.req_ready), 32'(oh(i)));
      exp_q.push_back(expw(i % 4));
      tick();
    end
    sample();
    chk("t3_ready_empty", 32'(bus.req_ready), 32'd0);
    chk("t3_credits_zero", 32'(credits_avail), 32'd0);
    tick();
    credit_return = 1'b1;
    sample();
    chk("t3_ready_ret", 32'(bus.req_ready), 32'd0);
    tick();
    credit_return = 1'b0;
    sample();
    chk("t3_ready_one", 32'(bus.req_ready), 32'(oh(0)));
    chk("t3_credits_one", 32'(credits_avail), 32'd1);
    exp_q.push_back(expw(0));
    tick();
    sample();
    chk("t3_ready_after", 32'(bus.req_ready), 32'd0);
    chk("t3_credits_after", 32'(credits_avail), 32'd0);
    bus.req_valid = '0;

    // T4: slow-link pacing, then speed-up during the gap
    do_reset();
    link_speed = LINK_100;
    bus.req_valid = 4'hF;
    for (int c = 0; c <= 20; c++) begin
      sample();
      if (c % 10 == 0) begin
        chk("t4_accept", 32'(bus.req_ready), 32'(oh(c / 10)));
        exp_q.push_back(expw(c / 10));
      end else begin
        chk("t4_gap", 32'(bus.req_ready), 32'd0);
      end
      tick();
    end
    sample();
    chk("t4_gap_a", 32'(bus.req_ready), 32'd0);
    tick();
    link_speed = LINK_1000;
    sample();
    chk("t4_gap_b", 32'(bus.req_ready), 32'd0);
    tick();
    sample();
    chk("t4_fast", 32'(bus.req_ready), 32'(oh(3)));
    exp_q.push_back(expw(3));
    tick();
    bus.req_valid = '0;
    sample();

    // T5: credit overflow is sticky until reset
    do_reset();
    credit_return = 1'b1;
    sample();
    chk("t5_err_pre", 32'(credit_err), 32'd0);
    tick();
    credit_return = 1'b0;
    sample();
    chk("t5_credits", 32'(credits_avail), 32'd8);
    chk("t5_err", 32'(credit_err), 32'd1);
    repeat (3) tick();
    sample();
    chk("t5_err_sticky", 32'(credit_err), 32'd1);
    do_reset();
    sample();
    chk("t5_err_cleared", 32'(credit_err), 32'd0);

    // T6: accept plus return at count 3, then reset during an accept
    do_reset();
    bus.req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("t6_ready", 32'(bus.req_ready), 32'(oh(i)));
      exp_q.push_back(expw(i % 4));
      tick();
    end
    credit_return = 1'b1;
    sample();
    chk("t6_credits_pre", 32'(credits_avail), 32'd3);
    chk("t6_ready_sim", 32'(bus.req_ready), 32'(oh(5)));
    exp_q.push_back(expw(1));
    tick();
    bus.req_valid = '0;
    credit_return = 1'b0;
    sample();
    chk("t6_credits_same", 32'(credits_avail), 32'd3);
    tick();
    bus.req_valid = 4'hF;
    reset = 1'b1;
    sample();
    chk("t6_ready_in_rst", 32'(bus.req_ready), 32'd0);
    tick();
    reset = 1'b0;
    sample();
    chk("t6_ovalid_drop", 32'(bus.ovalid), 32'd0);
    chk("t6_credits_rst", 32'(credits_avail), 32'd8);
    chk("t6_src0_wins", 32'(bus.req_ready), 32'(oh(0)));
    exp_q.push_back(expw(0));
    tick();
    bus.req_valid = '0;
    sample();

    repeat (4) tick();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
